shift_pipe_ctrl: RTL and testbench

SHIFT_PIPE_CTRL -- requirements
Module: shift_pipe_ctrl

---
 rtl/shift_pipe_ctrl_pkg.sv | 33 +++
 rtl/shift_mask_gen.sv | 35 +++
 rtl/shift_pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_shift_pipe_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pipe_ctrl_pkg.sv
// Shared types and widths for the shift pipeline controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package shift_pipe_ctrl_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int AMT_W_DEF  = $clog2(DATA_W_DEF);
  localparam int TAG_W_DEF  = 4;

  typedef enum logic [2:0] {
    OP_ROL = 3'd0,
    OP_ROR = 3'd1,
    OP_SLL = 3'd2,
    OP_SRL = 3'd3,
    OP_SRA = 3'd4
  } shift_op_e;

  // One pipe-stage record. Widths follow the package defaults, so the top's
  // DATA_W/TAG_W must stay at these values unless the package is changed too.
  typedef struct packed {
    shift_op_e              op;
    logic [DATA_W_DEF-1:0]  data;
    logic [AMT_W_DEF-1:0]   amt;
    logic [TAG_W_DEF-1:0]   tag;
    logic                   err;
  } stage_t;

  // Opcodes 5..7 have no meaning and are carried through as errors.
  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

endpackage

// File: rtl/shift_mask_gen.sv
// Builds the post-rotate keep-mask and sign-fill for a shift op and amount n.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle from the S1 record.
module shift_mask_gen
  import shift_pipe_ctrl_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  localparam int AMT_W  = $clog2(DATA_W)
) (
  input  logic [2:0]        op,
  input  logic [AMT_W-1:0]  n,
  input  logic              sign,
  output logic [DATA_W-1:0] mask,
  output logic [DATA_W-1:0] fill
);

  // Rotates keep every bit; logical shifts clear the bits that wrapped around;
  // SRA additionally replaces the wrapped top bits with the operand's sign.
  always_comb begin
    mask = {DATA_W{1'b1}};
    fill = '0;
    case (shift_op_e'(op))
      OP_SLL: mask = {DATA_W{1'b1}} << n;
      OP_SRL: mask = {DATA_W{1'b1}} >> n;
      OP_SRA: begin
        mask = {DATA_W{1'b1}} >> n;
        if (sign) begin
          fill = ~({DATA_W{1'b1}} >> n);
        end
      end
      default: mask = {DATA_W{1'b1}};
    endcase
  end

endmodule

// File: rtl/shift_pipe_ctrl.sv
// Two-stage shift/rotate controller around an external rotate-left stage.
// Latency: 2 cycles from acceptance to out_valid; one request per cycle.
// Backpressure: valid/ready; each stage advances when empty or draining, so bubbles collapse.
module shift_pipe_ctrl
  import shift_pipe_ctrl_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  TAG_W  = TAG_W_DEF,
  localparam int AMT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [DATA_W-1:0] rot_in,
  output logic [AMT_W-1:0]  rot_amt,
  input  logic [DATA_W-1:0] rot_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  logic              s1_valid;
  stage_t            s1_q;
  logic [AMT_W-1:0]  s1_rot_amt;

  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;
  logic [TAG_W-1:0]  s2_tag;
  logic              s2_err;

  logic              s1_adv;
  logic              s2_adv;

  stage_t            dec_stage;
  logic [AMT_W-1:0]  dec_rot_amt;

  logic [DATA_W-1:0] keep_mask;
  logic [DATA_W-1:0] sign_fill;
  logic [DATA_W-1:0] s2_next_data;

  // Handshake: in_ready only sees registered valids and out_ready, never in_valid.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Decode the incoming request. Right shifts and right rotates are done as a
  // left rotate by (DATA_W - amt) mod DATA_W, which wraps naturally in AMT_W bits.
  always_comb begin
    dec_stage      = '0;
    dec_stage.data = in_data;
    dec_stage.amt  = in_amt;
    dec_stage.tag  = in_tag;
    dec_stage.err  = !op_is_legal(in_op);
    dec_stage.op   = op_is_legal(in_op) ? shift_op_e'(in_op) : OP_ROL;
    dec_rot_amt    = '0;
    if (op_is_legal(in_op)) begin
      if (in_op == OP_ROL || in_op == OP_SLL) begin
        dec_rot_amt = in_amt;
      end else begin
        dec_rot_amt = {AMT_W{1'b0}} - in_amt;
      end
    end
  end

  // S1: register the decoded request; payload only loads on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_q       <= '0;
      s1_rot_amt <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q       <= dec_stage;
        s1_rot_amt <= dec_rot_amt;
      end
    end
  end

  // The rotator only ever sees registered S1 state.
  assign rot_in  = s1_q.data;
  assign rot_amt = s1_rot_amt;

  shift_mask_gen #(
    .DATA_W (DATA_W)
  ) u_mask_gen (
    .op   (s1_q.op),
    .n    (s1_q.amt),
    .sign (s1_q.data[DATA_W-1]),
    .mask (keep_mask),
    .fill (sign_fill)
  );

  // Illegal ops produce a zero result; everything else is the masked rotation.
  always_comb begin
    s2_next_data = (rot_result & keep_mask) | sign_fill;
    if (s1_q.err) begin
      s2_next_data = '0;
    end
  end

  // S2: capture the final result; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= s2_next_data;
        s2_tag  <= s1_q.tag;
        s2_err  <= s1_q.err;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_tag   = s2_tag;
  assign out_err   = s2_err;

endmodule

// File: tb/tb_shift_pipe_ctrl.sv
module tb_shift_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [63:0] in_data;
  logic [5:0]  in_amt;
  logic [3:0]  in_tag;
  logic [63:0] rot_in;
  logic [5:0]  rot_amt;
  logic [63:0] rot_result;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_tag;
  logic        out_err;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  shift_pipe_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_tag     (in_tag),
    .rot_in     (rot_in),
    .rot_amt    (rot_amt),
    .rot_result (rot_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_err    (out_err)
  );

  // External rotate-left stage model.
  always_comb rot_result = (rot_in << rot_amt) | (rot_in >> (7'd64 - {1'b0, rot_amt}));

  // Reference behaviour of each op, straight from the arithmetic definition.
  function automatic logic [63:0] ref_shift(input logic [2:0] op, input logic [63:0] d,
                                            input logic [5:0] a);
    int s;
    s = int'(a);
    case (op)
      3'd0:    return (d << s) | (d >> (64 - s));
      3'd1:    return (d >> s) | (d << (64 - s));
      3'd2:    return d << s;
      3'd3:    return d >> s;
      3'd4:    return 64'($signed(d) >>> s);
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          last_low = -1;
  logic        hold_q = 1'b0;
  logic [63:0] h_data;
  logic [3:0]  h_tag;
  logic        h_err;
  logic [63:0] last_data, prev_data;
  logic [3:0]  last_tag, prev_tag;
  logic        last_err, prev_err;
  int          last_cyc = 0, prev_cyc = 0, last_acc = 0;

  // Single compare process: scoreboard, latency, stability, throughput.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      hold_q = 1'b0;
    end else begin
      if (!out_ready) last_low = cycle;
      if (out_ready) chk("in_ready_with_out_ready", 64'(in_ready), 64'd1);
      if (hold_q) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", out_data, h_data);
        chk("hold_tag", 64'(out_tag), 64'(h_tag));
        chk("hold_err", 64'(out_err), 64'(h_err));
      end
      if (out_valid && out_ready) begin
        chk("no_phantom", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_tag", 64'(out_tag), 64'(e.tag));
          chk("sb_err", 64'(out_err), 64'(e.err));
          if (last_low < e.acc) chk("latency", 64'(cycle - e.acc), 64'd2);
          prev_data = last_data; prev_tag = last_tag; prev_err = last_err; prev_cyc = last_cyc;
          last_data = out_data;  last_tag = out_tag;  last_err = out_err;  last_cyc = cycle;
          last_acc  = e.acc;
        end
      end
      if (in_valid && in_ready) begin
        exp_t n;
        n.err  = (in_op > 3'd4);
        n.data = n.err ? 64'd0 : ref_shift(in_op, in_data, in_amt);
        n.tag  = in_tag;
        n.acc  = cycle;
        sb.push_back(n);
      end
      hold_q = out_valid && !out_ready;
      h_data = out_data; h_tag = out_tag; h_err = out_err;
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic send(input logic [2:0] op, input logic [63:0] d, input logic [5:0] a,
                      input logic [3:0] t);
    int n;
    n = 0;
    in_valid = 1'b1; in_op = op; in_data = d; in_amt = a; in_tag = t;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_last(input string name, input logic [63:0] d, input logic [3:0] t,
                             input logic e);
    chk({name, "_data"}, last_data, d);
    chk({name, "_tag"}, 64'(last_tag), 64'(t));
    chk({name, "_err"}, 64'(last_err), 64'(e));
  endtask

  logic [63:0] bp_data[5];
  logic [63:0] rnd;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_data = '0; in_amt = '0; in_tag = '0;
    out_ready = 1'b1;

    // Model pins: hand-computed values.
    chk("pin_sll", ref_shift(3'd2, 64'hF1, 6'd4), 64'hF10);
    chk("pin_sra", ref_shift(3'd4, 64'h8000_0000_0000_0000, 6'd63), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("pin_srl", ref_shift(3'd3, 64'h8000_0000_0000_0000, 6'd63), 64'h1);
    chk("pin_ror", ref_shift(3'd1, 64'h1, 6'd1), 64'h8000_0000_0000_0000);
    chk("pin_rol", ref_shift(3'd0, 64'h8000_0000_0000_0001, 6'd4), 64'h18);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_rot_in", rot_in, 64'd0);
    chk("rst_rot_amt", 64'(rot_amt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed shifts.
    send(3'd2, 64'hF1, 6'd4, 4'h1);
    idle(4);
    expect_last("sll", 64'hF10, 4'h1, 1'b0);
    chk("sll_latency", 64'(last_cyc - last_acc), 64'd2);
    send(3'd4, 64'h8000_0000_0000_0000, 6'd63, 4'h2);
    idle(4);
    expect_last("sra", 64'hFFFF_FFFF_FFFF_FFFF, 4'h2, 1'b0);
    send(3'd3, 64'h8000_0000_0000_0000, 6'd63, 4'h3);
    idle(4);
    expect_last("srl", 64'h1, 4'h3, 1'b0);
    send(3'd1, 64'h1, 6'd1, 4'h4);
    idle(4);
    expect_last("ror", 64'h8000_0000_0000_0000, 4'h4, 1'b0);
    for (int op = 0; op < 5; op++) begin
      rnd = {$urandom, $urandom};
      send(3'(op), rnd, 6'd0, 4'(op + 5));
      idle(4);
      expect_last("amt0", rnd, 4'(op + 5), 1'b0);
    end

    // Backpressure: consumer stalls while requests keep coming.
    for (int i = 0; i < 5; i++) bp_data[i] = {$urandom, $urandom};
    out_ready = 1'b0;
    begin
      int acc;
      acc = 0;
      in_valid = 1'b1; in_op = 3'd2; in_data = bp_data[0]; in_amt = 6'd3; in_tag = 4'h0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (in_ready) acc++;
        @(posedge clk); #1;
        if (acc < 5) begin in_data = bp_data[acc]; in_tag = 4'(acc); end
      end
      @(negedge clk);
      chk("bp_accepted", 64'(acc), 64'd2);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = acc; i < 5; i++) send(3'd2, bp_data[i], 6'd3, 4'(i));
    end
    idle(4);
    expect_last("bp_tail", bp_data[4] << 3, 4'h4, 1'b0);

    // Illegal op followed immediately by a legal one.
    send(3'd6, 64'hDEAD_BEEF, 6'd3, 4'hA);
    send(3'd2, 64'h3, 6'd1, 4'hB);
    idle(4);
    chk("ill_data", prev_data, 64'd0);
    chk("ill_err", 64'(prev_err), 64'd1);
    chk("ill_tag", 64'(prev_tag), 64'hA);
    expect_last("after_ill", 64'h6, 4'hB, 1'b0);
    chk("after_ill_gap", 64'(last_cyc - prev_cyc), 64'd1);

    // Reset with two requests in flight.
    out_ready = 1'b0;
    send(3'd0, 64'h55, 6'd1, 4'h1);
    send(3'd1, 64'h66, 6'd2, 4'h2);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_mid_no_phantom", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Random traffic.
    begin
      int acc_n, cyc;
      acc_n = 0; cyc = 0;
      while (acc_n < 10000 && cyc < 60000) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        in_op     = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        in_data   = {$urandom, $urandom};
        in_amt    = 6'($urandom);
        in_tag    = 4'($urandom);
        out_ready = ($urandom_range(0, 9) < 7);
        @(negedge clk);
        if (in_valid && in_ready) acc_n++;
        @(posedge clk); #1;
        cyc++;
      end
      chk("random_accepted", 64'(acc_n), 64'd10000);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(6);
    @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
